hazard_unit: RTL and testbench

- Load-use hazard detection unit for the 5-stage pipelined ARMv8 core.
- Compares the ID-stage source registers (Rn, Rm) with the destination (Rd) of a load currently in ID/EX.
- On a match it raises Stall, which freezes PC and IF/ID and injects a bubble into ID/EX.
- Also keeps a registered stall flag and a saturating stall counter for debug and performance visibility.

---
 rtl/hazard_unit.sv | 61 ++++++
 tb/tb_hazard_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: load-use hazard detection for the 5-stage ARMv8 pipeline.
// Detects a load in ID/EX whose destination feeds a source of the ID-stage
// instruction, and stalls PC/IF-ID while injecting a bubble into ID/EX.
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   Rn, Rm       - ID-stage source register indices
//   Rd, MemRead  - ID/EX destination register index and load flag
//   Stall        - combinational hazard flag (zero latency)
//   PCWrite      - PC write enable (NOT Stall)
//   IFIDWrite    - IF/ID write enable (NOT Stall)
//   CtrlBubble   - zero ID/EX control bits (equals Stall)
//   StallQ       - Stall delayed by one clock
//   StallCount   - saturating count of stalled cycles since reset
module hazard_unit #(
    parameter int unsigned XZR_INDEX = 31,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rn,
    input  logic [4:0]           Rm,
    input  logic [4:0]           Rd,
    input  logic                 MemRead,
    output logic                 Stall,
    output logic                 PCWrite,
    output logic                 IFIDWrite,
    output logic                 CtrlBubble,
    output logic                 StallQ,
    output logic [CNT_WIDTH-1:0] StallCount
);

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] XZR = REG_W'(XZR_INDEX);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic src_match;

    // XZR always reads as zero, so a load targeting it never creates a dependency
    always_comb begin
        src_match = (Rd == Rn) || (Rd == Rm);
        Stall     = MemRead && (Rd != XZR) && src_match;
    end

    assign PCWrite    = ~Stall;
    assign IFIDWrite  = ~Stall;
    assign CtrlBubble = Stall;

    // Debug/performance state: delayed stall flag and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallQ     <= 1'b0;
            StallCount <= '0;
        end else begin
            StallQ <= Stall;
            if (Stall && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized self-checking bench for hazard_unit against a
// behavioural model (hazard rule as a function, counter as a clamped integer).
module tb_hazard_unit;

    localparam int unsigned CNT_WIDTH = 16;
    localparam int          CNT_SAT   = (1 << CNT_WIDTH) - 1;
    localparam int          XZR       = 31;

    logic                 clk;
    logic                 rst_n;
    logic [4:0]           Rn;
    logic [4:0]           Rm;
    logic [4:0]           Rd;
    logic                 MemRead;
    logic                 Stall;
    logic                 PCWrite;
    logic                 IFIDWrite;
    logic                 CtrlBubble;
    logic                 StallQ;
    logic [CNT_WIDTH-1:0] StallCount;

    int n_checks;
    int n_errors;

    // Reference model state
    int model_cnt;
    bit model_q;

    hazard_unit #(
        .XZR_INDEX(31),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rn        (Rn),
        .Rm        (Rm),
        .Rd        (Rd),
        .MemRead   (MemRead),
        .Stall     (Stall),
        .PCWrite   (PCWrite),
        .IFIDWrite (IFIDWrite),
        .CtrlBubble(CtrlBubble),
        .StallQ    (StallQ),
        .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_stall(input int rn, input int rm, input int rd, input bit mr);
        if (!mr) return 1'b0;
        if (rd == XZR) return 1'b0;
        return (rd == rn) || (rd == rm);
    endfunction

    function automatic bit cur_stall();
        return ref_stall(int'(Rn), int'(Rm), int'(Rd), MemRead);
    endfunction

    task automatic check_comb(input string tag);
        bit e;
        e = cur_stall();
        check({tag, ".Stall"},      32'(Stall),      32'(e));
        check({tag, ".PCWrite"},    32'(PCWrite),    32'(!e));
        check({tag, ".IFIDWrite"},  32'(IFIDWrite),  32'(!e));
        check({tag, ".CtrlBubble"}, 32'(CtrlBubble), 32'(e));
    endtask

    task automatic check_state(input string tag);
        check({tag, ".StallQ"},     32'(StallQ),     32'(model_q));
        check({tag, ".StallCount"}, 32'(StallCount), 32'(model_cnt));
    endtask

    // Drive inputs and let the combinational path settle
    task automatic drive(input int rn, input int rm, input int rd, input bit mr);
        Rn      = 5'(rn);
        Rm      = 5'(rm);
        Rd      = 5'(rd);
        MemRead = mr;
        #1;
    endtask

    // Advance one clock; the model samples the current inputs at the edge
    task automatic step();
        bit e;
        e = cur_stall();
        @(posedge clk);
        #1;
        if (rst_n) begin
            model_q = e;
            if (e && model_cnt < CNT_SAT) model_cnt = model_cnt + 1;
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        model_q   = 1'b0;
        model_cnt = 0;
        check_state(tag);
        check_comb({tag, ".comb"});
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int rn, rm, rd, mode;
        bit mr;

        n_checks  = 0;
        n_errors  = 0;
        model_cnt = 0;
        model_q   = 1'b0;
        rst_n     = 1'b0;
        drive(0, 0, 0, 1'b0);

        // Reset state and combinational truth table while reset is held
        check_state("reset");
        drive(1, 1, 0, 1'b0); check_comb("mr0_110");
        drive(1, 2, 3, 1'b0); check_comb("mr0_123");
        drive(0, 0, 0, 1'b0); check_comb("mr0_000");
        drive(3, 2, 1, 1'b0); check_comb("mr0_321");
        drive(1, 1, 0, 1'b1); check_comb("mr1_110");
        drive(1, 2, 3, 1'b1); check_comb("mr1_123");
        drive(3, 2, 1, 1'b1); check_comb("mr1_321");
        drive(0, 0, 0, 1'b1); check_comb("mr1_000");
        check("x0_stall", 32'(Stall), 32'd1);
        drive(5, 9, 5, 1'b1); check_comb("rn_match");
        check("rn_match_abs", 32'(Stall), 32'd1);
        drive(9, 5, 5, 1'b1); check_comb("rm_match");
        drive(9, 5, 7, 1'b1); check_comb("no_match");
        check("no_match_abs", 32'(Stall), 32'd0);
        drive(31, 31, 31, 1'b1); check_comb("xzr");
        check("xzr_abs", 32'(Stall), 32'd0);
        check_state("reset_held");

        // Release reset away from the edge, then hold a hazard for 3 edges
        @(negedge clk);
        rst_n = 1'b1;
        drive(5, 9, 5, 1'b1);
        repeat (3) step();
        check_state("hold3");
        check("hold3_cnt_abs", 32'(StallCount), 32'd3);
        check("hold3_q_abs",   32'(StallQ),     32'd1);
        drive(5, 9, 5, 1'b0);
        step();
        check_state("release");
        check("release_cnt_abs", 32'(StallCount), 32'd3);

        // Randomized traffic biased toward matches and XZR destinations
        for (int i = 0; i < 2000; i++) begin
            rn   = int'($urandom_range(0, 31));
            rm   = int'($urandom_range(0, 31));
            mode = int'($urandom_range(0, 4));
            case (mode)
                0:       rd = rn;
                1:       rd = rm;
                2:       begin rd = XZR; if ($urandom_range(0, 1) != 0) rn = XZR; end
                3:       begin rd = rn; rm = rn; end
                default: rd = int'($urandom_range(0, 31));
            endcase
            mr = ($urandom_range(0, 3) != 0);
            drive(rn, rm, rd, mr);
            check_comb("rand");
            step();
            check_state("rand");
            if (i == 1000) reset_pulse("rand_rst");
        end

        // Saturation: hold a hazard long enough to pass all-ones
        drive(4, 4, 4, 1'b1);
        for (int i = 0; i < CNT_SAT + 4; i++) step();
        check_state("sat");
        check("sat_abs", 32'(StallCount), 32'hFFFF);
        repeat (3) step();
        check("sat_hold", 32'(StallCount), 32'hFFFF);
        check_state("sat_hold");

        // Mid-cycle reset clears state before the next edge
        #2;
        reset_pulse("sat_rst");
        check("sat_rst_abs", 32'(StallCount), 32'd0);
        step();
        check_state("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
